// File: rtl/core_pkg.sv
// Shared definitions for the writeback/commit stage: opcode encoding, FSM states
// and opcode-class helpers.
package core_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int OPW          = 6;

    typedef enum logic [OPW-1:0] {
        CU_ADD   = 6'd0,  CU_SUB   = 6'd1,  CU_ADDI  = 6'd2,  CU_AND   = 6'd3,
        CU_OR    = 6'd4,  CU_XOR   = 6'd5,  CU_SLL   = 6'd6,  CU_SRL   = 6'd7,
        CU_SRA   = 6'd8,  CU_SLT   = 6'd9,  CU_SLTU  = 6'd10, CU_LUI   = 6'd11,
        CU_AUIPC = 6'd12, CU_JAL   = 6'd13, CU_JALR  = 6'd14, CU_LB    = 6'd15,
        CU_LH    = 6'd16, CU_LW    = 6'd17, CU_LBU   = 6'd18, CU_LHU   = 6'd19,
        CU_SB    = 6'd20, CU_SH    = 6'd21, CU_SW    = 6'd22, CU_BEQ   = 6'd23,
        CU_BNE   = 6'd24, CU_BLT   = 6'd25, CU_BGE   = 6'd26, CU_BLTU  = 6'd27,
        CU_BGEU  = 6'd28, CU_ERROR = 6'd63
    } cu_op_t;

    typedef enum logic {S_IDLE, S_WAIT_MEM} wb_state_t;

    function automatic logic is_load(logic [OPW-1:0] op);
        return op inside {CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU};
    endfunction

    // Ops that retire without touching the register file.
    function automatic logic no_writeback(logic [OPW-1:0] op);
        return op inside {CU_SB, CU_SH, CU_SW, CU_BEQ, CU_BNE, CU_BLT,
                          CU_BGE, CU_BLTU, CU_BGEU, CU_ERROR};
    endfunction

endpackage

// File: rtl/wb_commit_unit_if.sv
// Retire-side handshake, memory read return and register-file write port of the commit stage.
interface wb_commit_unit_if #(
    parameter int XLEN   = core_pkg::XLEN_DEFAULT,
    parameter int REG_AW = 5
);
    logic                    in_valid;
    logic                    in_ready;
    logic [core_pkg::OPW-1:0] cuOP;
    logic [REG_AW-1:0]       rd;
    logic [XLEN-1:0]         aluOut;
    logic [XLEN-1:0]         pc;
    logic [XLEN-1:0]         imm;
    logic                    mem_rvalid;
    logic [XLEN-1:0]         memload;
    logic                    wb_we;
    logic [REG_AW-1:0]       wb_rd;
    logic [XLEN-1:0]         wb_data;
    logic                    err_misalign;
    logic                    err_timeout;

    modport master (
        output in_valid, cuOP, rd, aluOut, pc, imm, mem_rvalid, memload,
        input  in_ready, wb_we, wb_rd, wb_data, err_misalign, err_timeout
    );

    modport slave (
        input  in_valid, cuOP, rd, aluOut, pc, imm, mem_rvalid, memload,
        output in_ready, wb_we, wb_rd, wb_data, err_misalign, err_timeout
    );
endinterface

// File: rtl/wb_commit_unit_load_align.sv
// Picks the byte/half/word at the latched byte offset out of the memory word and
// sign- or zero-extends it to XLEN.
module load_align
    import core_pkg::*;
#(
    parameter  int XLEN = XLEN_DEFAULT,
    localparam int OFFW = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] memload,
    input  logic [OFFW-1:0] off,
    input  logic [OPW-1:0]  cuOP,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = memload >> {off, 3'b000};
        data    = shifted;
        case (cuOP)
            CU_LB:   data = XLEN'($signed(shifted[7:0]));
            CU_LBU:  data = XLEN'(shifted[7:0]);
            CU_LH:   data = XLEN'($signed(shifted[15:0]));
            CU_LHU:  data = XLEN'(shifted[15:0]);
            CU_LW:   data = XLEN'($signed(shifted[31:0]));
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: selects the retiring op's result, waits for load data with
// a timeout, and issues one registered register-file write per op.
//
//  state      | meaning
//  S_IDLE     | ready for a new op; non-loads and misaligned loads complete here
//  S_WAIT_MEM | aligned load accepted, waiting for mem_rvalid or timeout
module wb_commit_unit
    import core_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 255
) (
    input logic             clk,
    input logic             rst,
    wb_commit_unit_if.slave bus
);

    localparam int OFFW = $clog2(XLEN / 8);

    wb_state_t         state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [OPW-1:0]    op_q, op_d;
    logic [OFFW-1:0]   off_q, off_d;
    logic              wb_we_q, wb_we_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              err_mis_q, err_mis_d;
    logic              err_to_q, err_to_d;

    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   u_imm;
    logic [XLEN-1:0]   result;
    logic [OFFW-1:0]   addr_off;
    logic              misaligned;
    logic              unused_imm;

    assign unused_imm = ^bus.imm;
    assign u_imm      = XLEN'($signed({bus.imm[31:12], 12'h000}));
    assign addr_off   = bus.aluOut[OFFW-1:0];
    assign misaligned = ((bus.cuOP == CU_LH || bus.cuOP == CU_LHU) && addr_off[0])
                     || (bus.cuOP == CU_LW && addr_off[1:0] != 2'b00);

    load_align #(.XLEN(XLEN)) u_load_align (
        .memload (bus.memload),
        .off     (off_q),
        .cuOP    (op_q),
        .data    (load_data)
    );

    always_comb begin
        result = bus.aluOut;
        case (bus.cuOP)
            CU_LUI:          result = u_imm;
            CU_AUIPC:        result = bus.pc + u_imm;
            CU_JAL, CU_JALR: result = bus.pc + XLEN'(4);
            default:         result = bus.aluOut;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        op_d      = op_q;
        off_d     = off_q;
        wb_we_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        err_mis_d = 1'b0;
        err_to_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (is_load(bus.cuOP)) begin
                        if (misaligned) begin
                            err_mis_d = 1'b1;
                        end else begin
                            rd_d    = bus.rd;
                            op_d    = bus.cuOP;
                            off_d   = addr_off;
                            cnt_d   = '0;
                            state_d = S_WAIT_MEM;
                        end
                    end else if (!no_writeback(bus.cuOP)) begin
                        wb_we_d   = (bus.rd != '0);
                        wb_rd_d   = bus.rd;
                        wb_data_d = result;
                    end
                end
            end
            S_WAIT_MEM: begin
                // Data arriving on the final wait cycle takes priority over the timeout.
                if (bus.mem_rvalid) begin
                    wb_we_d   = (rd_q != '0);
                    wb_rd_d   = rd_q;
                    wb_data_d = load_data;
                    state_d   = S_IDLE;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    err_to_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rd_q      <= '0;
            op_q      <= '0;
            off_q     <= '0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            err_mis_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            op_q      <= op_d;
            off_q     <= off_d;
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            err_mis_q <= err_mis_d;
            err_to_q  <= err_to_d;
        end
    end

    assign bus.in_ready     = (state_q == S_IDLE);
    assign bus.wb_we        = wb_we_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.err_misalign = err_mis_q;
    assign bus.err_timeout  = err_to_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: a 32-bit and a 64-bit instance (TIMEOUT=8) share one set of
// stimulus variables; sel64 routes stimulus to, and observes outputs from, one of them.
module tb_wb_commit_unit;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, rvalid;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [63:0] alu, pc, imm, memload;
    bit          sel64;
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    wb_commit_unit_if #(.XLEN(32), .REG_AW(5)) bus32 ();
    wb_commit_unit_if #(.XLEN(64), .REG_AW(5)) bus64 ();

    assign bus32.in_valid   = in_valid & ~sel64;
    assign bus32.mem_rvalid = rvalid & ~sel64;
    assign bus32.cuOP       = op;
    assign bus32.rd         = rd;
    assign bus32.aluOut     = alu[31:0];
    assign bus32.pc         = pc[31:0];
    assign bus32.imm        = imm[31:0];
    assign bus32.memload    = memload[31:0];
    assign bus64.in_valid   = in_valid & sel64;
    assign bus64.mem_rvalid = rvalid & sel64;
    assign bus64.cuOP       = op;
    assign bus64.rd         = rd;
    assign bus64.aluOut     = alu;
    assign bus64.pc         = pc;
    assign bus64.imm        = imm;
    assign bus64.memload    = memload;

    wb_commit_unit #(.XLEN(32), .REG_AW(5), .TIMEOUT(8)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    wb_commit_unit #(.XLEN(64), .REG_AW(5), .TIMEOUT(8)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

    wire        o_ready = sel64 ? bus64.in_ready     : bus32.in_ready;
    wire        o_we    = sel64 ? bus64.wb_we        : bus32.wb_we;
    wire [4:0]  o_rd    = sel64 ? bus64.wb_rd        : bus32.wb_rd;
    wire [63:0] o_data  = sel64 ? bus64.wb_data      : {32'h0, bus32.wb_data};
    wire        o_mis   = sel64 ? bus64.err_misalign : bus32.err_misalign;
    wire        o_to    = sel64 ? bus64.err_timeout  : bus32.err_timeout;

    logic [5:0] nl_ops [16] = '{CU_ADD, CU_SUB, CU_ADDI, CU_XOR, CU_SLL, CU_SLT, CU_LUI, CU_AUIPC,
                                CU_JAL, CU_JALR, CU_SW, CU_SB, CU_BEQ, CU_BGEU, CU_ERROR, 6'd40};
    logic [5:0] ld_ops [5]  = '{CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU};

    // ---------------- reference model ----------------
    function automatic logic [63:0] fit(logic [63:0] v);
        return sel64 ? v : {32'h0, v[31:0]};
    endfunction

    function automatic bit has_wb(logic [5:0] o);
        return !(o inside {CU_SB, CU_SH, CU_SW, CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU, CU_ERROR});
    endfunction

    function automatic logic [63:0] exp_result(logic [5:0] o, logic [63:0] a, logic [63:0] p, logic [63:0] i);
        logic [63:0] u;
        u = {{32{i[31]}}, i[31:12], 12'h000};
        if (o == CU_LUI)                   return fit(u);
        if (o == CU_AUIPC)                 return fit(p + u);
        if (o == CU_JAL || o == CU_JALR)   return fit(p + 64'd4);
        return fit(a);
    endfunction

    function automatic bit exp_misalign(logic [5:0] o, logic [63:0] a);
        return ((o == CU_LH || o == CU_LHU) && (a % 2 != 0)) || (o == CU_LW && (a % 4 != 0));
    endfunction

    function automatic logic [63:0] exp_load(logic [5:0] o, logic [63:0] a, logic [63:0] m);
        int nb, off;
        logic [63:0] v;
        nb  = (o == CU_LB || o == CU_LBU) ? 1 : (o == CU_LW) ? 4 : 2;
        off = sel64 ? int'(a % 8) : int'(a % 4);
        v   = 64'h0;
        for (int k = 0; k < nb; k++)
            v = v | (((m >> (8 * (off + k))) & 64'hFF) << (8 * k));
        if ((o == CU_LB || o == CU_LH || o == CU_LW) && v[8*nb-1])
            v = v | (~64'h0 << (8 * nb));
        return fit(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 0; rvalid = 0; op = CU_ADD; rd = 0;
        alu = 0; pc = 0; imm = 0; memload = 0; sel64 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        tick();
        for (int s = 0; s < 2; s++) begin
            sel64 = s[0];
            #1;
            tests_run++; if (o_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready w%0d got %b want 1", s, o_ready); end
            tests_run++; if (o_we !== 1'b0)    begin tests_failed++; $display("FAIL reset_we w%0d got %b want 0", s, o_we); end
            tests_run++; if (o_rd !== 5'd0)    begin tests_failed++; $display("FAIL reset_rd w%0d got %0d want 0", s, o_rd); end
            tests_run++; if (o_data !== 64'h0) begin tests_failed++; $display("FAIL reset_data w%0d got %h want 0", s, o_data); end
            tests_run++; if (o_mis !== 1'b0 || o_to !== 1'b0) begin tests_failed++; $display("FAIL reset_err w%0d got %b%b want 00", s, o_mis, o_to); end
        end
        sel64 = 0;
    endtask

    task automatic test_addi();
        @(negedge clk) begin in_valid = 1; op = CU_ADDI; rd = 5; alu = 64'h1234; end
        tick();
        tests_run++; if (o_we !== 1'b1)         begin tests_failed++; $display("FAIL addi_we got %b want 1", o_we); end
        tests_run++; if (o_rd !== 5'd5)         begin tests_failed++; $display("FAIL addi_rd got %0d want 5", o_rd); end
        tests_run++; if (o_data !== 64'h1234)   begin tests_failed++; $display("FAIL addi_data got %h want 1234", o_data); end
        @(negedge clk) in_valid = 0;
        tick();
        tests_run++; if (o_we !== 1'b0)         begin tests_failed++; $display("FAIL addi_we_pulse got %b want 0", o_we); end
    endtask

    task automatic test_back_to_back();
        bit exp_we;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk) begin
                sel64 = (i % 3 == 0);
                in_valid = 1;
                op  = nl_ops[$urandom_range(0, 15)];
                rd  = (i % 7 == 0) ? 5'd0 : 5'($urandom);
                alu = {$urandom, $urandom}; pc = {$urandom, $urandom}; imm = {$urandom, $urandom};
            end
            tick();
            exp_we = has_wb(op) && (rd != 0);
            tests_run++; if (o_we !== exp_we)   begin tests_failed++; $display("FAIL b2b_we i=%0d op=%0d got %b want %b", i, op, o_we, exp_we); end
            tests_run++; if (o_ready !== 1'b1)  begin tests_failed++; $display("FAIL b2b_ready i=%0d got %b want 1", i, o_ready); end
            if (exp_we) begin
                tests_run++;
                if (o_rd !== rd || o_data !== exp_result(op, alu, pc, imm)) begin
                    tests_failed++;
                    $display("FAIL b2b_data i=%0d op=%0d got rd=%0d %h want rd=%0d %h", i, op, o_rd, o_data, rd, exp_result(op, alu, pc, imm));
                end
            end
        end
        @(negedge clk) begin in_valid = 0; sel64 = 0; end
    endtask

    task automatic test_lb_lbu();
        logic [63:0] want;
        for (int v = 0; v < 2; v++) begin
            @(negedge clk) begin in_valid = 1; op = (v == 0) ? CU_LB : CU_LBU; rd = 7; alu = 64'h1003; end
            tick();
            tests_run++; if (o_ready !== 1'b0) begin tests_failed++; $display("FAIL lb_accept v%0d got ready=%b want 0", v, o_ready); end
            @(negedge clk) in_valid = 0;
            tick();
            tick();
            @(negedge clk) begin rvalid = 1; memload = 64'h80FF_0000; end
            tick();
            want = (v == 0) ? 64'hFFFF_FF80 : 64'h0000_0080;
            tests_run++; if (o_we !== 1'b1 || o_rd !== 5'd7) begin tests_failed++; $display("FAIL lb_we v%0d got we=%b rd=%0d want 1 7", v, o_we, o_rd); end
            tests_run++; if (o_data !== want)  begin tests_failed++; $display("FAIL lb_data v%0d got %h want %h", v, o_data, want); end
            tests_run++; if (o_ready !== 1'b1) begin tests_failed++; $display("FAIL lb_ready v%0d got %b want 1", v, o_ready); end
            @(negedge clk) rvalid = 0;
        end
    endtask

    task automatic test_misalign();
        @(negedge clk) begin in_valid = 1; op = CU_LH; rd = 3; alu = 64'h1001; end
        tick();
        tests_run++; if (o_mis !== 1'b1)   begin tests_failed++; $display("FAIL mis_pulse got %b want 1", o_mis); end
        tests_run++; if (o_we !== 1'b0)    begin tests_failed++; $display("FAIL mis_we got %b want 0", o_we); end
        tests_run++; if (o_ready !== 1'b1) begin tests_failed++; $display("FAIL mis_ready got %b want 1", o_ready); end
        @(negedge clk) in_valid = 0;
        tick();
        tests_run++; if (o_mis !== 1'b0)   begin tests_failed++; $display("FAIL mis_pulse_end got %b want 0", o_mis); end
    endtask

    task automatic test_auipc_jal();
        @(negedge clk) begin in_valid = 1; op = CU_AUIPC; rd = 9; pc = 64'h1000; imm = 64'h0000_1000; end
        tick();
        tests_run++; if (o_we !== 1'b1 || o_data !== 64'h2000) begin tests_failed++; $display("FAIL auipc got we=%b %h want 1 2000", o_we, o_data); end
        @(negedge clk) begin op = CU_JAL; rd = 0; pc = 64'h1000; end
        tick();
        tests_run++; if (o_we !== 1'b0)    begin tests_failed++; $display("FAIL jal_rd0_we got %b want 0", o_we); end
        @(negedge clk) in_valid = 0;
    endtask

    task automatic test_timeout(input bit with_rv, input logic [4:0] rdv);
        @(negedge clk) begin in_valid = 1; op = CU_LW; rd = rdv; alu = 64'h2000; end
        tick();
        @(negedge clk) in_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 8 && with_rv) @(negedge clk) begin rvalid = 1; memload = 64'h1234_5678; end
            tick();
            if (k < 8) begin
                tests_run++; if (o_to !== 1'b0 || o_ready !== 1'b0) begin tests_failed++; $display("FAIL to_wait k=%0d got to=%b ready=%b want 0 0", k, o_to, o_ready); end
            end else if (with_rv) begin
                tests_run++; if (o_we !== 1'b1 || o_data !== 64'h1234_5678 || o_to !== 1'b0) begin tests_failed++; $display("FAIL to_late_rv got we=%b %h to=%b want 1 12345678 0", o_we, o_data, o_to); end
            end else begin
                tests_run++; if (o_to !== 1'b1 || o_we !== 1'b0 || o_ready !== 1'b1) begin tests_failed++; $display("FAIL to_fire rd=%0d got to=%b we=%b ready=%b want 1 0 1", rdv, o_to, o_we, o_ready); end
            end
        end
        @(negedge clk) rvalid = 0;
        tick();
        tests_run++; if (o_to !== 1'b0 || o_ready !== 1'b1) begin tests_failed++; $display("FAIL to_after got to=%b ready=%b want 0 1", o_to, o_ready); end
    endtask

    task automatic test_random_loads();
        int dly;
        bit mis;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk) begin
                sel64 = i[0];
                in_valid = 1;
                op  = ld_ops[$urandom_range(0, 4)];
                rd  = (i % 9 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                alu = {$urandom, $urandom};
                if ($urandom_range(0, 3) != 0) begin
                    if (op == CU_LH || op == CU_LHU) alu[0] = 1'b0;
                    if (op == CU_LW) alu[1:0] = 2'b00;
                end
            end
            dly = $urandom_range(0, 5);
            mis = exp_misalign(op, alu);
            tick();
            if (mis) begin
                tests_run++; if (o_mis !== 1'b1 || o_we !== 1'b0 || o_ready !== 1'b1) begin tests_failed++; $display("FAIL rl_mis i=%0d got mis=%b we=%b ready=%b want 1 0 1", i, o_mis, o_we, o_ready); end
                @(negedge clk) in_valid = 0;
            end else begin
                tests_run++; if (o_ready !== 1'b0 || o_mis !== 1'b0) begin tests_failed++; $display("FAIL rl_accept i=%0d got ready=%b mis=%b want 0 0", i, o_ready, o_mis); end
                @(negedge clk) in_valid = 0;
                for (int d = 0; d < dly; d++) begin
                    memload = {$urandom, $urandom};
                    tick();
                    @(negedge clk);
                end
                rvalid = 1; memload = {$urandom, $urandom};
                tick();
                tests_run++; if (o_we !== (rd != 0) || o_ready !== 1'b1) begin tests_failed++; $display("FAIL rl_we i=%0d got we=%b ready=%b want %b 1", i, o_we, o_ready, rd != 0); end
                if (rd != 0) begin
                    tests_run++;
                    if (o_rd !== rd || o_data !== exp_load(op, alu, memload)) begin
                        tests_failed++;
                        $display("FAIL rl_data i=%0d op=%0d addr=%h got rd=%0d %h want rd=%0d %h", i, op, alu, o_rd, o_data, rd, exp_load(op, alu, memload));
                    end
                end
                @(negedge clk) rvalid = 0;
            end
        end
        sel64 = 0;
    endtask

    task automatic test_rvalid_idle();
        @(negedge clk) begin rvalid = 1; memload = 64'hDEAD_BEEF; end
        tick();
        tests_run++; if (o_we !== 1'b0 || o_ready !== 1'b1) begin tests_failed++; $display("FAIL rv_idle got we=%b ready=%b want 0 1", o_we, o_ready); end
        @(negedge clk) rvalid = 0;
    endtask

    task automatic test_reset_abort();
        bit saw_err;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk) begin sel64 = s[0]; in_valid = 1; op = CU_LW; rd = 6; alu = 64'h40; end
            tick();
            @(negedge clk) in_valid = 0;
            tick();
            tick();
            @(negedge clk) rst = 1;
            #1;
            tests_run++; if (o_ready !== 1'b1 || o_we !== 1'b0) begin tests_failed++; $display("FAIL abort_rst w%0d got ready=%b we=%b want 1 0", s, o_ready, o_we); end
            @(negedge clk) rst = 0;
            @(negedge clk) begin rvalid = 1; memload = 64'h5555_AAAA; end
            tick();
            tests_run++; if (o_we !== 1'b0 || o_ready !== 1'b1) begin tests_failed++; $display("FAIL abort_late_rv w%0d got we=%b ready=%b want 0 1", s, o_we, o_ready); end
            @(negedge clk) rvalid = 0;
            saw_err = 0;
            for (int k = 0; k < 12; k++) begin
                tick();
                if (o_to || o_mis || o_we) saw_err = 1;
            end
            tests_run++; if (saw_err !== 1'b0) begin tests_failed++; $display("FAIL abort_quiet w%0d got activity=%b want 0", s, saw_err); end
        end
        sel64 = 0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_lb_lbu();
        test_misalign();
        test_auipc_jal();
        test_timeout(1'b0, 5'd4);
        test_timeout(1'b1, 5'd4);
        test_timeout(1'b0, 5'd0);
        test_random_loads();
        test_rvalid_idle();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
